// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: runs one req/ack transaction per load or
// store, stalls upstream while it is outstanding and registers the MEM/WB bundle.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk_MemAcc,
  input  logic        rst_MemAcc,
  input  logic        valid_in_MemAcc,
  input  logic [31:0] ALU_in_MemAcc,
  input  logic [31:0] Rs2_in_MemAcc,
  input  logic        MemRW_in_MemAcc,
  input  logic [1:0]  MemtoReg_in_MemAcc,
  input  logic [4:0]  Rd_addr_in_MemAcc,
  input  logic        RegWrite_in_MemAcc,
  input  logic [31:0] PC4_in_MemAcc,
  output logic        stall_out_MemAcc,
  output logic        dmem_req_out_MemAcc,
  output logic        dmem_we_out_MemAcc,
  output logic [31:0] dmem_addr_out_MemAcc,
  output logic [31:0] dmem_wdata_out_MemAcc,
  input  logic        dmem_ack_in_MemAcc,
  input  logic [31:0] dmem_rdata_in_MemAcc,
  output logic        valid_out_MemAcc,
  output logic [4:0]  Rd_addr_out_MemAcc,
  output logic        RegWrite_out_MemAcc,
  output logic [1:0]  MemtoReg_out_MemAcc,
  output logic [31:0] ALU_out_MemAcc,
  output logic [31:0] Mem_data_out_MemAcc,
  output logic [31:0] PC4_out_MemAcc,
  output logic        err_out_MemAcc
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Transaction latches, captured only when a memory op is accepted in IDLE
  logic [31:0] addr_reg, wdata_reg, alu_reg, pc4_reg;
  logic        we_reg, regwrite_reg;
  logic [4:0]  rd_reg;
  logic [1:0]  memtoreg_reg;
  logic        err_reg;

  logic        wb_valid_reg, wb_valid_next;
  logic [4:0]  wb_rd_reg, wb_rd_next;
  logic        wb_regwrite_reg, wb_regwrite_next;
  logic [1:0]  wb_memtoreg_reg, wb_memtoreg_next;
  logic [31:0] wb_alu_reg, wb_alu_next;
  logic [31:0] wb_mdata_reg, wb_mdata_next;
  logic [31:0] wb_pc4_reg, wb_pc4_next;

  logic        need_mem, busy, acked, timed_out, accept_mem;
  logic        stall_c, req_c, we_c;
  logic [31:0] load_data;

  assign need_mem   = valid_in_MemAcc & (MemRW_in_MemAcc | (MemtoReg_in_MemAcc == 2'b01));
  assign busy       = (state_reg == BUSY);
  assign acked      = busy & dmem_ack_in_MemAcc;
  assign timed_out  = busy & ~dmem_ack_in_MemAcc & (cnt_reg == CNT_LAST);
  assign accept_mem = (state_reg == IDLE) & need_mem;

  // Stores return no data, so the read bus is masked per bit by the latched we
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_load_data
      assign load_data[gi] = dmem_rdata_in_MemAcc[gi] & ~we_reg;
    end
  endgenerate

  always_ff @(posedge clk_MemAcc) begin
    if (rst_MemAcc) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (need_mem) state_next = BUSY;
      BUSY: if (acked || timed_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_c          = 1'b0;
    req_c            = 1'b0;
    we_c             = 1'b0;
    cnt_next         = '0;
    wb_valid_next    = 1'b0;
    wb_rd_next       = '0;
    wb_regwrite_next = 1'b0;
    wb_memtoreg_next = '0;
    wb_alu_next      = '0;
    wb_mdata_next    = '0;
    wb_pc4_next      = '0;
    case (state_reg)
      IDLE: begin
        if (need_mem) begin
          stall_c = 1'b1;
        end else if (valid_in_MemAcc) begin
          wb_valid_next    = 1'b1;
          wb_rd_next       = Rd_addr_in_MemAcc;
          wb_regwrite_next = RegWrite_in_MemAcc;
          wb_memtoreg_next = MemtoReg_in_MemAcc;
          wb_alu_next      = ALU_in_MemAcc;
          wb_pc4_next      = PC4_in_MemAcc;
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        we_c    = we_reg;
        stall_c = ~dmem_ack_in_MemAcc & ~timed_out;
        if (!(acked || timed_out)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // An abort still retires the slot, but without a register write
        if (acked || timed_out) begin
          wb_valid_next    = 1'b1;
          wb_rd_next       = rd_reg;
          wb_regwrite_next = acked ? regwrite_reg : 1'b0;
          wb_memtoreg_next = memtoreg_reg;
          wb_alu_next      = alu_reg;
          wb_mdata_next    = acked ? load_data : 32'h0;
          wb_pc4_next      = pc4_reg;
        end
      end
      default: begin
        stall_c = 1'b0;
      end
    endcase
    if (rst_MemAcc) begin
      stall_c = 1'b0;
      req_c   = 1'b0;
      we_c    = 1'b0;
    end
  end

  always_ff @(posedge clk_MemAcc) begin
    if (rst_MemAcc) begin
      cnt_reg         <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      alu_reg         <= '0;
      pc4_reg         <= '0;
      we_reg          <= 1'b0;
      regwrite_reg    <= 1'b0;
      rd_reg          <= '0;
      memtoreg_reg    <= '0;
      err_reg         <= 1'b0;
      wb_valid_reg    <= 1'b0;
      wb_rd_reg       <= '0;
      wb_regwrite_reg <= 1'b0;
      wb_memtoreg_reg <= '0;
      wb_alu_reg      <= '0;
      wb_mdata_reg    <= '0;
      wb_pc4_reg      <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (accept_mem) begin
        addr_reg     <= ALU_in_MemAcc;
        wdata_reg    <= Rs2_in_MemAcc;
        we_reg       <= MemRW_in_MemAcc;
        alu_reg      <= ALU_in_MemAcc;
        pc4_reg      <= PC4_in_MemAcc;
        regwrite_reg <= RegWrite_in_MemAcc;
        rd_reg       <= Rd_addr_in_MemAcc;
        memtoreg_reg <= MemtoReg_in_MemAcc;
      end
      if (timed_out) begin
        err_reg <= 1'b1;
      end
      wb_valid_reg    <= wb_valid_next;
      wb_rd_reg       <= wb_rd_next;
      wb_regwrite_reg <= wb_regwrite_next;
      wb_memtoreg_reg <= wb_memtoreg_next;
      wb_alu_reg      <= wb_alu_next;
      wb_mdata_reg    <= wb_mdata_next;
      wb_pc4_reg      <= wb_pc4_next;
    end
  end

  assign stall_out_MemAcc      = stall_c;
  assign dmem_req_out_MemAcc   = req_c;
  assign dmem_we_out_MemAcc    = we_c;
  assign dmem_addr_out_MemAcc  = addr_reg;
  assign dmem_wdata_out_MemAcc = wdata_reg;
  assign valid_out_MemAcc      = wb_valid_reg;
  assign Rd_addr_out_MemAcc    = wb_rd_reg;
  assign RegWrite_out_MemAcc   = wb_regwrite_reg;
  assign MemtoReg_out_MemAcc   = wb_memtoreg_reg;
  assign ALU_out_MemAcc        = wb_alu_reg;
  assign Mem_data_out_MemAcc   = wb_mdata_reg;
  assign PC4_out_MemAcc        = wb_pc4_reg;
  assign err_out_MemAcc        = err_reg;

endmodule
